// File: rtl/thread_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory port, decode output slot,
// downstream redirect and per-thread halt control.
interface thread_fetch_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_ir;
    logic [DATA_W-1:0] out_pc;
    logic              out_thread;
    logic [3:0]        out_pre;
    logic              out_preit;
    logic              redirect_valid;
    logic              redirect_thread;
    logic [DATA_W-1:0] redirect_pc;
    logic [1:0]        halt_req;
    logic              halt;

    modport master (
        output imem_addr,
        input  imem_data,
        output out_valid,
        input  out_ready,
        output out_ir,
        output out_pc,
        output out_thread,
        output out_pre,
        output out_preit,
        input  redirect_valid,
        input  redirect_thread,
        input  redirect_pc,
        input  halt_req,
        output halt
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        input  out_valid,
        output out_ready,
        input  out_ir,
        input  out_pc,
        input  out_thread,
        input  out_pre,
        input  out_preit,
        output redirect_valid,
        output redirect_thread,
        output redirect_pc,
        output halt_req,
        input  halt
    );
endinterface

// File: rtl/thread_fetch.sv
// Two-thread round-robin instruction fetch with a single output slot.
// Optional prefix-word fusion is enabled by defining PREFIX_FUSE_EN.
module thread_fetch #(
    parameter int DATA_W = 16
) (
    input  logic           clk,
    input  logic           reset,
    thread_fetch_if.master bus
);

    function automatic logic [DATA_W-1:0] pc_inc(input logic [DATA_W-1:0] pc);
        return pc + 1'b1;
    endfunction

    logic [DATA_W-1:0] pc_q [2];
    logic [1:0]        halted_q;
    logic              rr_q;

    logic              vld_p1;
    logic [DATA_W-1:0] ir_p1;
    logic [DATA_W-1:0] pc_p1;
    logic              thr_p1;
    logic              halt_p1;

    logic [1:0] elig;
    logic [1:0] halted_nxt;
    logic       sel;
    logic       discard;
    logic       slot_free;
    logic       issue;
    logic       emit;
    logic       redir_ok;
    logic       is_pre;

    // A thread being redirected this cycle may not fetch from its stale PC.
    always_comb begin
        elig[0]    = !halted_q[0] && !(bus.redirect_valid && !bus.redirect_thread);
        elig[1]    = !halted_q[1] && !(bus.redirect_valid &&  bus.redirect_thread);
        sel        = elig[rr_q] ? rr_q : ~rr_q;
        discard    = bus.redirect_valid && vld_p1 && (thr_p1 == bus.redirect_thread);
        slot_free  = !vld_p1 || bus.out_ready || discard;
        issue      = elig[sel] && slot_free;
        emit       = issue && !is_pre;
        halted_nxt = halted_q | bus.halt_req;
        redir_ok   = bus.redirect_valid && !halted_nxt[bus.redirect_thread];
    end

    assign bus.imem_addr  = pc_q[sel];
    assign bus.out_valid  = vld_p1;
    assign bus.out_ir     = ir_p1;
    assign bus.out_pc     = pc_p1;
    assign bus.out_thread = thr_p1;
    assign bus.halt       = halt_p1;

    // ---- p0 -> p1: fetch address stage into output slot ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q[0]  <= '0;
            pc_q[1]  <= '0;
            halted_q <= 2'b00;
            rr_q     <= 1'b0;
            vld_p1   <= 1'b0;
            ir_p1    <= '0;
            pc_p1    <= '0;
            thr_p1   <= 1'b0;
            halt_p1  <= 1'b0;
        end else begin
            halted_q <= halted_nxt;
            halt_p1  <= &halted_nxt;
            if (issue) begin
                pc_q[sel] <= pc_inc(pc_q[sel]);
                rr_q      <= ~sel;
            end
            // Never collides with the issue update: a redirected thread is ineligible.
            if (redir_ok)
                pc_q[bus.redirect_thread] <= bus.redirect_pc;
            if (emit) begin
                vld_p1 <= 1'b1;
                ir_p1  <= bus.imem_data;
                pc_p1  <= pc_q[sel];
                thr_p1 <= sel;
            end else if (discard || (vld_p1 && bus.out_ready)) begin
                vld_p1 <= 1'b0;
            end
        end
    end

`ifdef PREFIX_FUSE_EN
    logic [3:0] pre_q [2];
    logic [1:0] preit_q;
    logic [3:0] pre_p1;
    logic       preit_p1;

    assign is_pre        = (bus.imem_data[DATA_W-1 -: 4] == 4'hF);
    assign bus.out_pre   = pre_p1;
    assign bus.out_preit = preit_p1;

    // Prefix words are absorbed here and attached to the thread's next emitted word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pre_q[0] <= 4'h0;
            pre_q[1] <= 4'h0;
            preit_q  <= 2'b00;
            pre_p1   <= 4'h0;
            preit_p1 <= 1'b0;
        end else begin
            if (issue && is_pre) begin
                pre_q[sel]   <= bus.imem_data[3:0];
                preit_q[sel] <= 1'b1;
            end else if (emit) begin
                pre_p1       <= preit_q[sel] ? pre_q[sel] : 4'h0;
                preit_p1     <= preit_q[sel];
                preit_q[sel] <= 1'b0;
            end
            if (bus.redirect_valid)
                preit_q[bus.redirect_thread] <= 1'b0;
        end
    end
`else
    assign is_pre        = 1'b0;
    assign bus.out_pre   = 4'h0;
    assign bus.out_preit = 1'b0;
`endif

endmodule

// File: tb/tb_thread_fetch.sv
// Directed bench for thread_fetch: reset, round-robin, backpressure, redirect,
// halt, PC wrap and prefix handling (expectations follow PREFIX_FUSE_EN).
module tb_thread_fetch;

    logic clk;
    logic reset;
    logic [15:0] mem [0:65535];
    int n_checks;
    int n_fail;

    thread_fetch_if #(.DATA_W(16)) bus ();

    thread_fetch #(.DATA_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.imem_data = mem[bus.imem_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset               = 1'b0;
        bus.out_ready       = 1'b1;
        bus.redirect_valid  = 1'b0;
        bus.redirect_thread = 1'b0;
        bus.redirect_pc     = 16'h0000;
        bus.halt_req        = 2'b00;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset;
        logic [33:0] obs;
        do_reset();
        reset = 1'b0;
        tick();
        obs = {bus.out_valid, bus.out_thread, bus.out_pc, bus.out_ir};
        n_checks++;
        if (obs !== 34'h0) begin
            n_fail++;
            $display("FAIL reset_out: got %h want %h", obs, 34'h0);
        end
        n_checks++;
        if ({bus.out_pre, bus.out_preit, bus.halt} !== 6'h0) begin
            n_fail++;
            $display("FAIL reset_pre_halt: got %h want 0", {bus.out_pre, bus.out_preit, bus.halt});
        end
        n_checks++;
        if (bus.imem_addr !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_addr: got %h want 0000", bus.imem_addr);
        end
        // Mid-operation reset drops the held word; restart at T0 pc 0
        reset = 1'b1;
        tick();
        tick();
        tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_valid: got %b want 0", bus.out_valid);
        end
        reset = 1'b1;
        tick();
        obs = {bus.out_valid, bus.out_thread, bus.out_pc, bus.out_ir};
        n_checks++;
        if (obs !== {1'b1, 1'b0, 16'h0000, 16'h1000}) begin
            n_fail++;
            $display("FAIL midreset_resume: got %h want %h", obs, {1'b1, 1'b0, 16'h0000, 16'h1000});
        end
    endtask

    task automatic test_round_robin;
        logic [33:0] obs;
        logic [33:0] exp [4];
        exp[0] = {1'b1, 1'b0, 16'h0000, 16'h1000};
        exp[1] = {1'b1, 1'b1, 16'h0000, 16'h1000};
        exp[2] = {1'b1, 1'b0, 16'h0001, 16'h2000};
        exp[3] = {1'b1, 1'b1, 16'h0001, 16'h2000};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            obs = {bus.out_valid, bus.out_thread, bus.out_pc, bus.out_ir};
            n_checks++;
            if (obs !== exp[i]) begin
                n_fail++;
                $display("FAIL rr_%0d: got %h want %h", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [33:0] obs;
        logic [33:0] exp [3];
        exp[0] = {1'b1, 1'b0, 16'h0001, 16'h2000};
        exp[1] = {1'b1, 1'b1, 16'h0001, 16'h2000};
        exp[2] = {1'b1, 1'b0, 16'h0002, 16'h3002};
        do_reset();
        tick();
        tick();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            obs = {bus.out_valid, bus.out_thread, bus.out_pc, bus.out_ir};
            n_checks++;
            if (obs !== {1'b1, 1'b1, 16'h0000, 16'h1000} || bus.imem_addr !== 16'h0001) begin
                n_fail++;
                $display("FAIL stall_%0d: got %h addr %h want %h addr 0001",
                         i, obs, bus.imem_addr, {1'b1, 1'b1, 16'h0000, 16'h1000});
            end
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            obs = {bus.out_valid, bus.out_thread, bus.out_pc, bus.out_ir};
            n_checks++;
            if (obs !== exp[i]) begin
                n_fail++;
                $display("FAIL resume_%0d: got %h want %h", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_redirect;
        logic [33:0] obs;
        do_reset();
        for (int i = 0; i < 12; i++) tick();
        obs = {bus.out_valid, bus.out_thread, bus.out_pc, bus.out_ir};
        n_checks++;
        if (obs !== {1'b1, 1'b1, 16'h0005, 16'h3005}) begin
            n_fail++;
            $display("FAIL redir_setup: got %h want %h", obs, {1'b1, 1'b1, 16'h0005, 16'h3005});
        end
        bus.out_ready       = 1'b0;
        bus.redirect_valid  = 1'b1;
        bus.redirect_thread = 1'b1;
        bus.redirect_pc     = 16'h0040;
        tick();
        obs = {bus.out_valid, bus.out_thread, bus.out_pc, bus.out_ir};
        n_checks++;
        if (obs !== {1'b1, 1'b0, 16'h0006, 16'h3006}) begin
            n_fail++;
            $display("FAIL redir_discard: got %h want %h", obs, {1'b1, 1'b0, 16'h0006, 16'h3006});
        end
        bus.redirect_valid = 1'b0;
        bus.out_ready      = 1'b1;
        tick();
        obs = {bus.out_valid, bus.out_thread, bus.out_pc, bus.out_ir};
        n_checks++;
        if (obs !== {1'b1, 1'b1, 16'h0040, 16'h3040}) begin
            n_fail++;
            $display("FAIL redir_target: got %h want %h", obs, {1'b1, 1'b1, 16'h0040, 16'h3040});
        end
        tick();
        obs = {bus.out_valid, bus.out_thread, bus.out_pc, bus.out_ir};
        n_checks++;
        if (obs !== {1'b1, 1'b0, 16'h0007, 16'h3007}) begin
            n_fail++;
            $display("FAIL redir_after: got %h want %h", obs, {1'b1, 1'b0, 16'h0007, 16'h3007});
        end
    endtask

    task automatic test_halt;
        logic [33:0] obs;
        logic [33:0] exp [4];
        exp[0] = {1'b1, 1'b0, 16'h0000, 16'h1000};
        exp[1] = {1'b1, 1'b1, 16'h0000, 16'h1000};
        exp[2] = {1'b1, 1'b1, 16'h0001, 16'h2000};
        exp[3] = {1'b1, 1'b1, 16'h0002, 16'h3002};
        do_reset();
        bus.halt_req = 2'b01;
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.halt_req = 2'b00;
            obs = {bus.out_valid, bus.out_thread, bus.out_pc, bus.out_ir};
            n_checks++;
            if (obs !== exp[i] || bus.halt !== 1'b0) begin
                n_fail++;
                $display("FAIL halt0_%0d: got %h halt %b want %h halt 0", i, obs, bus.halt, exp[i]);
            end
        end
        bus.halt_req = 2'b10;
        tick();
        bus.halt_req = 2'b00;
        obs = {bus.out_valid, bus.out_thread, bus.out_pc, bus.out_ir};
        n_checks++;
        if (obs !== {1'b1, 1'b1, 16'h0003, 16'h3003} || bus.halt !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_both: got %h halt %b want %h halt 1",
                     obs, bus.halt, {1'b1, 1'b1, 16'h0003, 16'h3003});
        end
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.halt !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_drain: got valid %b halt %b want valid 0 halt 1", bus.out_valid, bus.halt);
        end
    endtask

    task automatic test_pc_wrap;
        logic [33:0] obs;
        logic [33:0] exp [4];
        exp[0] = {1'b1, 1'b1, 16'h0000, 16'h1000};
        exp[1] = {1'b1, 1'b0, 16'hFFFF, 16'h3FFF};
        exp[2] = {1'b1, 1'b1, 16'h0001, 16'h2000};
        exp[3] = {1'b1, 1'b0, 16'h0000, 16'h1000};
        do_reset();
        bus.redirect_valid  = 1'b1;
        bus.redirect_thread = 1'b0;
        bus.redirect_pc     = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                n_checks++;
                if (bus.imem_addr !== 16'h0000) begin
                    n_fail++;
                    $display("FAIL wrap_addr: got %h want 0000", bus.imem_addr);
                end
            end
            tick();
            bus.redirect_valid = 1'b0;
            obs = {bus.out_valid, bus.out_thread, bus.out_pc, bus.out_ir};
            n_checks++;
            if (obs !== exp[i]) begin
                n_fail++;
                $display("FAIL wrap_%0d: got %h want %h", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_prefix;
        logic [38:0] obs;
        logic [38:0] exp [5];
`ifdef PREFIX_FUSE_EN
        exp[0] = 39'h0;
        exp[1] = 39'h0;
        exp[2] = {1'b1, 1'b0, 16'h0001, 16'h1234, 4'hA, 1'b1};
        exp[3] = {1'b1, 1'b1, 16'h0001, 16'h1234, 4'hA, 1'b1};
        exp[4] = {1'b1, 1'b0, 16'h0002, 16'h3002, 4'h0, 1'b0};
`else
        exp[0] = {1'b1, 1'b0, 16'h0000, 16'hF00A, 4'h0, 1'b0};
        exp[1] = {1'b1, 1'b1, 16'h0000, 16'hF00A, 4'h0, 1'b0};
        exp[2] = {1'b1, 1'b0, 16'h0001, 16'h1234, 4'h0, 1'b0};
        exp[3] = {1'b1, 1'b1, 16'h0001, 16'h1234, 4'h0, 1'b0};
        exp[4] = {1'b1, 1'b0, 16'h0002, 16'h3002, 4'h0, 1'b0};
`endif
        mem[0] = 16'hF00A;
        mem[1] = 16'h1234;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            obs = {bus.out_valid, bus.out_thread, bus.out_pc, bus.out_ir, bus.out_pre, bus.out_preit};
            n_checks++;
            if (obs !== exp[i]) begin
                n_fail++;
                $display("FAIL prefix_%0d: got %h want %h", i, obs, exp[i]);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int a = 0; a < 65536; a++) mem[a] = {4'h3, a[11:0]};
        mem[0] = 16'h1000;
        mem[1] = 16'h2000;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_redirect();
        test_halt();
        test_pc_wrap();
        test_prefix();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/thread_fetch.md
THREAD_FETCH -- requirements
Module: thread_fetch

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on posedge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-low; sampled on posedge clk.
REQ-003 SHALL have port: imem_addr  out  16  instruction-memory word address (combinational from selected thread PC).
REQ-004 SHALL have port: imem_data  in  16  instruction word, valid in the same cycle as imem_addr.
REQ-005 SHALL have port: out_valid  out  1  output slot holds an instruction for decode.
REQ-006 SHALL have port: out_ready  in  1  decode accepts; transfer when out_valid && out_ready.
REQ-007 SHALL have ports: out_ir  out  16  instruction; out_pc  out  16  its address; out_thread  out  1  owning thread.
REQ-008 SHALL have ports: out_pre  out  4  fused prefix value; out_preit  out  1  prefix present.
REQ-009 SHALL have ports: redirect_valid  in  1; redirect_thread  in  1; redirect_pc  in  16  jump/call/ret target from downstream.
REQ-010 SHALL have ports: halt_req  in  2  per-thread halt request (bit t = thread t); halt  out  1  both threads halted.

Function
REQ-011 SHALL keep per-thread 16-bit PC, per-thread halted flag, and a 1-bit round-robin pointer rr.
REQ-012 SHALL select thread sel = rr, unless rr is halted or redirected this cycle, then sel = ~rr; no issue if both are ineligible.
REQ-013 SHALL issue a fetch when sel is eligible and slot is free (out_valid==0 or out_ready==1); imem_addr = PC[sel].
REQ-014 On issue, SHALL at the next edge load out_ir=imem_data, out_pc=PC[sel], out_thread=sel, out_valid=1, PC[sel]=PC[sel]+1 (wraps FFFF->0000), rr=~sel.
REQ-015 When no issue occurs and a transfer completes, SHALL clear out_valid; when out_valid && !out_ready, all out_* SHALL hold unchanged.
REQ-016 Single-instruction latency: address presented cycle N -> out_valid at edge ending cycle N; sustained throughput one instruction per cycle, alternating threads when both are active.
REQ-017 On redirect_valid, SHALL load PC[redirect_thread]=redirect_pc at the next edge; that thread SHALL not issue in the same cycle.
REQ-018 On redirect_valid with out_valid && out_thread==redirect_thread, SHALL discard the held instruction (out_valid=0 next edge unless the other thread issues into the slot), regardless of out_ready.
REQ-019 Redirect to a halted thread SHALL be ignored (PC unchanged).
REQ-020 halt_req[t] SHALL set halted[t] at the next edge; halted flags are sticky until reset; a same-cycle issue for t is still allowed to complete.
REQ-021 halt SHALL equal halted[0] && halted[1], registered.
REQ-022 Simultaneous redirect and halt_req for the same thread: halt wins, PC unchanged.

Reset
REQ-023 With reset==0 at posedge: PC[0]=PC[1]=0, halted=00, rr=0, out_valid=0, out_ir=0, out_pc=0, out_thread=0, out_pre=0, out_preit=0, halt=0, prefix state cleared.
REQ-024 Reset mid-operation SHALL discard the held instruction and any pending prefix; fetch resumes at address 0 for thread 0 in the first cycle after reset deasserts.

Configuration
REQ-025 Macro PREFIX_FUSE_EN: when defined, a fetched word with imem_data[15:12]==4'hF (pre) SHALL not be emitted; it sets pre[sel]=imem_data[3:0], preit[sel]=1, PC advances, rr toggles.
REQ-026 With PREFIX_FUSE_EN, the next emitted instruction of that thread SHALL carry out_pre=pre[t], out_preit=1, then preit[t] clears; a redirect of t SHALL clear preit[t].
REQ-027 Without PREFIX_FUSE_EN, pre words SHALL be emitted as ordinary instructions; out_pre=0, out_preit=0 always.

Verification
REQ-028 Reset, out_ready=1, mem[0]=1000,mem[1]=2000 -> outputs (T0,pc0,1000),(T1,pc0,1000),(T0,pc1,2000),(T1,pc1,2000) on consecutive cycles.
REQ-029 Hold out_ready=0 three cycles with slot full -> out_* constant, PCs unchanged, imem not advanced; release -> stream resumes with no loss/duplication.
REQ-030 Slot holds T1 pc5, assert redirect T1->0040 with out_ready=0 -> T1 pc5 discarded, next T1 output pc 0040.
REQ-031 halt_req=01 -> only T1 fetched every cycle; then halt_req=10 -> halt=1 one cycle later, out_valid drops after drain.
REQ-032 PREFIX_FUSE_EN, T0 mem: F00A,1234 -> single T0 output ir=1234, out_pre=A, out_preit=1; without macro -> two outputs F00A, 1234 with out_preit=0.
REQ-033 PC[0]=FFFF via redirect -> fetch FFFF, next T0 fetch address 0000.
